execute_bru: RTL and testbench
==============================

Name: execute_bru

Overview:
- Combinational branch/jump execution unit of the out-of-order core.
- Pops issued BRU ops from the issue→BRU FIFO and resolves jal/jalr/conditional branches/mret.
- Drives the BRU writeback port register (we/flush) and the bypass feedback channel.
- Sends resolved outcome and checkpoint to the branch predictor.

Parameters:
- ADDR_WIDTH, 32, PC/target width (`ADDR_WIDTH).
- REG_DATA_WIDTH, 32, register data width (`REG_DATA_WIDTH).
- INSTRUCTION_WIDTH, 32, instruction word width (`INSTRUCTION_WIDTH).
- CHECKPOINT_ID_WIDTH, `CHECKPOINT_ID_WIDTH, checkpoint buffer index width.

Ports:
- clk  in  1  clock, single domain
- rst  in  1  reset, asynchronous, active-low
- exbru_cpbuf_id  out  CHECKPOINT_ID_WIDTH  checkpoint buffer read index
- cpbuf_exbru_data  in  checkpoint_t  checkpoint read data
- exbru_bp_cp  out  checkpoint_t  checkpoint to predictor
- exbru_bp_pc  out  ADDR_WIDTH  branch pc
- exbru_bp_instruction  out  INSTRUCTION_WIDTH  instruction word (pack.value)
- exbru_bp_jump  out  1  resolved taken
- exbru_bp_next_pc  out  ADDR_WIDTH  resolved next pc
- exbru_bp_hit  out  1  prediction correct
- exbru_bp_valid  out  1  predictor update strobe
- csrf_all_mepc_data  in  REG_DATA_WIDTH  current mepc
- issue_bru_fifo_data_out  in  issue_execute_pack_t  FIFO head
- issue_bru_fifo_data_out_valid  in  1  FIFO non-empty
- issue_bru_fifo_pop  out  1  pop FIFO head
- bru_wb_port_data_in  out  execute_wb_pack_t  writeback register data
- bru_wb_port_we  out  1  writeback register write enable
- bru_wb_port_flush  out  1  writeback register clear
- bru_execute_channel_feedback_pack  out  execute_feedback_channel_t  bypass result
- commit_feedback_pack  in  commit_feedback_pack_t  commit-stage feedback (enable, flush used)

Behaviour:
- Purely combinational datapath; clk unused. rst gates outputs only.
- Reset asserted (rst=0, async): pop=0, we=0, flush=1, feedback.enable=0, bp_valid=0, wb data all zero.
- cflush = commit_feedback_pack.enable & commit_feedback_pack.flush.
- go = rst & data_out_valid & !cflush.
- pop=go, we=go, flush=!go. cflush dominates FIFO valid.
- Head with enable=0 is still popped/written; wb pack has enable=0.
- Wb pack copies all common fields from head: enable, valid, rob_id, pc, imm, exception fields, predicted fields, checkpoint fields, rd, rd_enable, need_rename, rd_phy, csr, op, op_unit, sub_op.
- exec = enable & valid & !has_exception.
- If !exec: rd_value=0, bru_jump=0, bru_next_pc=pc+4.
- If exec, by sub_op.bru_op; s1=src1_value, s2=src2_value:
  - jal: rd_value=pc+4, jump=1, next=pc+imm.
  - jalr: rd_value=pc+4, jump=1, next=(s1+imm)&~1.
  - beq/bne/blt/bge/bltu/bgeu: rd_value=0; jump=condition (blt/bge signed, bltu/bgeu unsigned); next=jump?pc+imm:pc+4.
  - mret: rd_value=0, jump=1, next=csrf_all_mepc_data.
- Arithmetic is modulo 2^ADDR_WIDTH, wrapping.
- Feedback channel:
  - enable = go & exec & rd_enable & need_rename.
  - phy_id = rd_phy, value = rd_value.
  - Fields are zero when enable=0.
- Predictor interface:
  - exbru_cpbuf_id = checkpoint_id; exbru_bp_cp = cpbuf_exbru_data (pass-through).
  - bp_pc=pc, bp_instruction=value, bp_jump=bru_jump, bp_next_pc=bru_next_pc.
  - bp_valid = go & exec & checkpoint_id_valid.
  - bp_hit = (jump==predicted_jump) & (!jump | next_pc==predicted_next_pc).

Test Plan:
- Reset, then idle with FIFO empty → we=0, flush=1, pop=0, feedback.enable=0.
- Head enable=1, valid=0, exception illegal_instruction, fifo valid=1 → we=1, flush=0, pop=1; wb enable=1, valid=0, has_exception=1, exception_id=illegal_instruction; feedback off.
- jal: pc=0x1526c2d8, imm=0x18745658, rd_phy=10, rd_enable=1, need_rename=1, predicted_jump=0, cp_id=35 valid → rd_value=pc+4, next=pc+imm, jump=1; feedback phy 10 value pc+4; bp_hit=0, bp_valid=1, cpbuf_id=35; bp_cp = cpbuf data (local_history 0x1574a2dc).
- mret, mepc=0x15251224 → bp_jump=1, bp_next_pc=0x15251224, bp_hit=0.
- beq equal (0x15286679 both) → jump=1, next=pc+imm, rd_value=0, bp_hit=0. beq unequal (0x15286679 vs 0x1528667a) → jump=0, next=pc+4, bp_hit=1.
- commit enable=1, flush=0 → normal processing; then flush=1 → we=0, flush=1, pop=0, feedback off, with FIFO valid.

Source files
------------

// File: rtl/execute_bru.sv
// execute_bru: combinational branch/jump resolution unit with writeback, bypass and predictor ports
package execute_bru_pkg;
    localparam int ADDR_WIDTH          = 32;
    localparam int REG_DATA_WIDTH      = 32;
    localparam int INSTRUCTION_WIDTH   = 32;
    localparam int CHECKPOINT_ID_WIDTH = 6;
    localparam int ROB_ID_WIDTH        = 7;
    localparam int PHY_REG_ID_WIDTH    = 6;
    localparam int EXC_ID_WIDTH        = 5;
    localparam logic [EXC_ID_WIDTH-1:0] EXC_ILLEGAL_INSTRUCTION = 5'd2;

    typedef enum logic [3:0] {
        BRU_JAL, BRU_JALR, BRU_BEQ, BRU_BNE, BRU_BLT, BRU_BGE, BRU_BLTU, BRU_BGEU, BRU_MRET
    } bru_op_t;

    typedef struct packed {
        bru_op_t bru_op;
    } sub_op_t;

    typedef struct packed {
        logic [31:0] local_history;
        logic [31:0] global_history;
    } checkpoint_t;

    typedef struct packed {
        logic                           enable;
        logic                           valid;
        logic [ROB_ID_WIDTH-1:0]        rob_id;
        logic [ADDR_WIDTH-1:0]          pc;
        logic [ADDR_WIDTH-1:0]          imm;
        logic                           has_exception;
        logic [EXC_ID_WIDTH-1:0]        exception_id;
        logic [REG_DATA_WIDTH-1:0]      exception_value;
        logic                           predicted;
        logic                           predicted_jump;
        logic [ADDR_WIDTH-1:0]          predicted_next_pc;
        logic                           checkpoint_id_valid;
        logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
        logic [4:0]                     rd;
        logic                           rd_enable;
        logic                           need_rename;
        logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
        logic [11:0]                    csr;
        logic [3:0]                     op;
        logic [2:0]                     op_unit;
        sub_op_t                        sub_op;
    } common_pack_t;

    typedef struct packed {
        common_pack_t                   c;
        logic [INSTRUCTION_WIDTH-1:0]   value;
        logic [REG_DATA_WIDTH-1:0]      src1_value;
        logic [REG_DATA_WIDTH-1:0]      src2_value;
    } issue_execute_pack_t;

    typedef struct packed {
        common_pack_t                   c;
        logic [REG_DATA_WIDTH-1:0]      rd_value;
        logic                           bru_jump;
        logic [ADDR_WIDTH-1:0]          bru_next_pc;
    } execute_wb_pack_t;

    typedef struct packed {
        logic                           enable;
        logic [PHY_REG_ID_WIDTH-1:0]    phy_id;
        logic [REG_DATA_WIDTH-1:0]      value;
    } execute_feedback_channel_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;
endpackage

module execute_bru
    import execute_bru_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    output logic [CHECKPOINT_ID_WIDTH-1:0]  exbru_cpbuf_id,
    input  checkpoint_t                     cpbuf_exbru_data,
    output checkpoint_t                     exbru_bp_cp,
    output logic [ADDR_WIDTH-1:0]           exbru_bp_pc,
    output logic [INSTRUCTION_WIDTH-1:0]    exbru_bp_instruction,
    output logic                            exbru_bp_jump,
    output logic [ADDR_WIDTH-1:0]           exbru_bp_next_pc,
    output logic                            exbru_bp_hit,
    output logic                            exbru_bp_valid,
    input  logic [REG_DATA_WIDTH-1:0]       csrf_all_mepc_data,
    input  issue_execute_pack_t             issue_bru_fifo_data_out,
    input  logic                            issue_bru_fifo_data_out_valid,
    output logic                            issue_bru_fifo_pop,
    output execute_wb_pack_t                bru_wb_port_data_in,
    output logic                            bru_wb_port_we,
    output logic                            bru_wb_port_flush,
    output execute_feedback_channel_t       bru_execute_channel_feedback_pack,
    input  commit_feedback_pack_t           commit_feedback_pack
);
    issue_execute_pack_t       head;
    execute_wb_pack_t          wb;
    execute_feedback_channel_t fb;
    logic                      cflush, go, exec, cond, jump, fb_en, unused_ok;
    logic [ADDR_WIDTH-1:0]     pc_plus4, pc_plus_imm, jalr_sum, next_pc;
    logic [REG_DATA_WIDTH-1:0] rd_value;

    assign head      = issue_bru_fifo_data_out;
    assign unused_ok = clk;

    // Resolve the taken flag, next pc and link value of the FIFO head
    always_comb begin
        exec        = head.c.enable & head.c.valid & ~head.c.has_exception;
        pc_plus4    = head.c.pc + ADDR_WIDTH'(4);
        pc_plus_imm = head.c.pc + head.c.imm;
        jalr_sum    = head.src1_value + head.c.imm;
        case (head.c.sub_op.bru_op)
            BRU_BEQ:  cond = head.src1_value == head.src2_value;
            BRU_BNE:  cond = head.src1_value != head.src2_value;
            BRU_BLT:  cond = $signed(head.src1_value) < $signed(head.src2_value);
            BRU_BGE:  cond = $signed(head.src1_value) >= $signed(head.src2_value);
            BRU_BLTU: cond = head.src1_value < head.src2_value;
            BRU_BGEU: cond = head.src1_value >= head.src2_value;
            default:  cond = 1'b0;
        endcase
        jump     = 1'b0;
        next_pc  = pc_plus4;
        rd_value = '0;
        if (exec) begin
            case (head.c.sub_op.bru_op)
                BRU_JAL:  {jump, next_pc, rd_value} = {1'b1, pc_plus_imm, pc_plus4};
                BRU_JALR: {jump, next_pc, rd_value} = {1'b1, jalr_sum[ADDR_WIDTH-1:1], 1'b0, pc_plus4};
                BRU_MRET: {jump, next_pc} = {1'b1, csrf_all_mepc_data};
                default:  {jump, next_pc} = {cond, cond ? pc_plus_imm : pc_plus4};
            endcase
        end
    end

    // Gate the resolved op onto the FIFO, writeback, bypass and predictor ports
    always_comb begin
        cflush                            = commit_feedback_pack.enable & commit_feedback_pack.flush;
        go                                = rst & issue_bru_fifo_data_out_valid & ~cflush;
        issue_bru_fifo_pop                = go;
        bru_wb_port_we                    = go;
        bru_wb_port_flush                 = ~go;
        wb.c                              = head.c;
        wb.rd_value                       = rd_value;
        wb.bru_jump                       = jump;
        wb.bru_next_pc                    = next_pc;
        bru_wb_port_data_in               = rst ? wb : execute_wb_pack_t'('0);
        fb_en                             = go & exec & head.c.rd_enable & head.c.need_rename;
        fb.enable                         = 1'b1;
        fb.phy_id                         = head.c.rd_phy;
        fb.value                          = rd_value;
        bru_execute_channel_feedback_pack = fb_en ? fb : execute_feedback_channel_t'('0);
        exbru_cpbuf_id                    = head.c.checkpoint_id;
        exbru_bp_cp                       = cpbuf_exbru_data;
        exbru_bp_pc                       = head.c.pc;
        exbru_bp_instruction              = head.value;
        exbru_bp_jump                     = jump;
        exbru_bp_next_pc                  = next_pc;
        exbru_bp_valid                    = go & exec & head.c.checkpoint_id_valid;
        exbru_bp_hit                      = (jump == head.c.predicted_jump) & (~jump | (next_pc == head.c.predicted_next_pc));
    end
endmodule

// File: tb/tb_execute_bru.sv
// tb_execute_bru: vector table, hand sequences and randomized model check for execute_bru
module tb_execute_bru;
    import execute_bru_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [5:0]                cpbuf_id;
    checkpoint_t               cpd, bp_cp;
    logic [31:0]               bp_pc, bp_instr, bp_next, mepc;
    logic                      bp_jump, bp_hit, bp_valid, fv, pop, we, flush;
    issue_execute_pack_t       head;
    execute_wb_pack_t          wb;
    execute_feedback_channel_t fb;
    commit_feedback_pack_t     cm;
    int                        n_tests = 0;
    int                        n_fail = 0;

    always #5 clk = ~clk;

    execute_bru dut (
        .clk(clk), .rst(rst),
        .exbru_cpbuf_id(cpbuf_id), .cpbuf_exbru_data(cpd), .exbru_bp_cp(bp_cp),
        .exbru_bp_pc(bp_pc), .exbru_bp_instruction(bp_instr), .exbru_bp_jump(bp_jump),
        .exbru_bp_next_pc(bp_next), .exbru_bp_hit(bp_hit), .exbru_bp_valid(bp_valid),
        .csrf_all_mepc_data(mepc),
        .issue_bru_fifo_data_out(head), .issue_bru_fifo_data_out_valid(fv), .issue_bru_fifo_pop(pop),
        .bru_wb_port_data_in(wb), .bru_wb_port_we(we), .bru_wb_port_flush(flush),
        .bru_execute_channel_feedback_pack(fb), .commit_feedback_pack(cm)
    );

    typedef struct {
        string                 name;
        issue_execute_pack_t   head;
        logic                  fv, r;
        commit_feedback_pack_t cm;
        logic [31:0]           mepc;
        logic                  we, flush, pop, fb_en, jump, hit, bp_valid;
        logic [31:0]           next, rd_value;
    } vec_t;

    typedef struct packed {
        logic                      pop, we, flush;
        execute_wb_pack_t          wb;
        execute_feedback_channel_t fb;
        logic                      bp_jump, bp_hit, bp_valid;
        logic [31:0]               bp_next;
    } exp_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic issue_execute_pack_t mk(input logic en, input logic vl, input logic exc, input bru_op_t op,
                                               input logic [31:0] pc, input logic [31:0] imm,
                                               input logic [31:0] s1, input logic [31:0] s2);
        issue_execute_pack_t h;
        h = '0;
        h.c.enable = en;
        h.c.valid = vl;
        h.c.has_exception = exc;
        h.c.exception_id = exc ? EXC_ILLEGAL_INSTRUCTION : 5'd0;
        h.c.sub_op.bru_op = op;
        h.c.pc = pc;
        h.c.imm = imm;
        h.c.rob_id = 7'd3;
        h.c.rd = 5'd1;
        h.c.rd_phy = 6'd10;
        h.c.rd_enable = 1'b1;
        h.c.need_rename = 1'b1;
        h.c.checkpoint_id = 6'd35;
        h.c.checkpoint_id_valid = 1'b1;
        h.value = 32'h0000_006f;
        h.src1_value = s1;
        h.src2_value = s2;
        return h;
    endfunction

    function automatic vec_t vec(input string nm, input issue_execute_pack_t h, input logic f, input logic r,
                                 input logic ce, input logic cf, input logic [31:0] me,
                                 input logic e_we, input logic e_fl, input logic e_pop, input logic e_fb,
                                 input logic e_j, input logic [31:0] e_nx, input logic e_hit,
                                 input logic e_bv, input logic [31:0] e_rd);
        vec_t v;
        v.name = nm; v.head = h; v.fv = f; v.r = r; v.cm.enable = ce; v.cm.flush = cf; v.mepc = me;
        v.we = e_we; v.flush = e_fl; v.pop = e_pop; v.fb_en = e_fb; v.jump = e_j; v.next = e_nx;
        v.hit = e_hit; v.bp_valid = e_bv; v.rd_value = e_rd;
        return v;
    endfunction

    // Reference: straight from the resolution rules, signed/unsigned compares done on 64-bit integers
    function automatic exp_t model(input issue_execute_pack_t h, input logic f, input logic r,
                                   input commit_feedback_pack_t c, input logic [31:0] me);
        exp_t e;
        logic ok, live;
        longint as, bs, au, bu;
        logic [31:0] seq, tgt, link;
        e = '0;
        ok = r && f && !(c.enable && c.flush);
        live = h.c.enable && h.c.valid && !h.c.has_exception;
        as = longint'($signed(h.src1_value));
        bs = longint'($signed(h.src2_value));
        au = longint'({32'd0, h.src1_value});
        bu = longint'({32'd0, h.src2_value});
        seq = h.c.pc + 32'd4;
        tgt = h.c.pc + h.c.imm;
        link = 32'd0;
        e.bp_jump = 1'b0;
        e.bp_next = seq;
        if (live) begin
            if (h.c.sub_op.bru_op == BRU_JAL) begin
                e.bp_jump = 1'b1; e.bp_next = tgt; link = seq;
            end else if (h.c.sub_op.bru_op == BRU_JALR) begin
                e.bp_jump = 1'b1; e.bp_next = (h.src1_value + h.c.imm) & 32'hffff_fffe; link = seq;
            end else if (h.c.sub_op.bru_op == BRU_MRET) begin
                e.bp_jump = 1'b1; e.bp_next = me;
            end else begin
                if (h.c.sub_op.bru_op == BRU_BEQ)  e.bp_jump = au == bu;
                if (h.c.sub_op.bru_op == BRU_BNE)  e.bp_jump = au != bu;
                if (h.c.sub_op.bru_op == BRU_BLT)  e.bp_jump = as < bs;
                if (h.c.sub_op.bru_op == BRU_BGE)  e.bp_jump = as >= bs;
                if (h.c.sub_op.bru_op == BRU_BLTU) e.bp_jump = au < bu;
                if (h.c.sub_op.bru_op == BRU_BGEU) e.bp_jump = au >= bu;
                if (e.bp_jump) e.bp_next = tgt;
            end
        end
        e.pop = ok;
        e.we = ok;
        e.flush = !ok;
        if (r) begin
            e.wb.c = h.c;
            e.wb.rd_value = link;
            e.wb.bru_jump = e.bp_jump;
            e.wb.bru_next_pc = e.bp_next;
        end
        if (ok && live && h.c.rd_enable && h.c.need_rename) begin
            e.fb.enable = 1'b1;
            e.fb.phy_id = h.c.rd_phy;
            e.fb.value = link;
        end
        e.bp_valid = ok && live && h.c.checkpoint_id_valid;
        e.bp_hit = (e.bp_jump == h.c.predicted_jump) && (!e.bp_jump || e.bp_next == h.c.predicted_next_pc);
        return e;
    endfunction

    task automatic apply(input issue_execute_pack_t h, input logic f, input logic r,
                         input commit_feedback_pack_t c, input logic [31:0] me);
        @(negedge clk);
        head = h; fv = f; rst = r; cm = c; mepc = me;
        #1;
    endtask

    localparam logic [31:0] P = 32'h1526c2d8;
    localparam logic [31:0] I = 32'h18745658;

    initial begin
        issue_execute_pack_t h;
        commit_feedback_pack_t c0;
        logic [319:0] rb;
        exp_t e;
        vec_t v;
        c0 = '0;
        rst = 1'b0; fv = 1'b0; head = '0; cm = '0; mepc = '0;
        cpd.local_history = 32'h1574a2dc;
        cpd.global_history = 32'h0000_00a5;
        #12;
        chk("reset.we", 512'(we), 512'(1'b0));
        chk("reset.flush", 512'(flush), 512'(1'b1));
        chk("reset.pop", 512'(pop), 512'(1'b0));
        chk("reset.wb", 512'(wb), 512'(0));
        rst = 1'b1;

        tbl.push_back(vec("idle", mk(0,0,0,BRU_JAL,P,I,0,0), 0,1,0,0,0, 0,1,0,0, 0,P+4,1,0,0));
        tbl.push_back(vec("exc", mk(1,0,1,BRU_JAL,P,I,0,0), 1,1,0,0,0, 1,0,1,0, 0,P+4,1,0,0));
        tbl.push_back(vec("jal", mk(1,1,0,BRU_JAL,P,I,0,0), 1,1,0,0,0, 1,0,1,1, 1,P+I,0,1,P+4));
        tbl.push_back(vec("mret", mk(1,1,0,BRU_MRET,P,I,0,0), 1,1,0,0,32'h15251224, 1,0,1,1, 1,32'h15251224,0,1,0));
        tbl.push_back(vec("beq_eq", mk(1,1,0,BRU_BEQ,P,I,32'h15286679,32'h15286679), 1,1,0,0,0, 1,0,1,1, 1,P+I,0,1,0));
        tbl.push_back(vec("beq_ne", mk(1,1,0,BRU_BEQ,P,I,32'h15286679,32'h1528667a), 1,1,0,0,0, 1,0,1,1, 0,P+4,1,1,0));
        tbl.push_back(vec("bne_ne", mk(1,1,0,BRU_BNE,P,I,32'h15286679,32'h1528667a), 1,1,0,0,0, 1,0,1,1, 1,P+I,0,1,0));
        tbl.push_back(vec("blt_neg", mk(1,1,0,BRU_BLT,P,I,32'hfffffff0,32'd5), 1,1,0,0,0, 1,0,1,1, 1,P+I,0,1,0));
        tbl.push_back(vec("bltu_neg", mk(1,1,0,BRU_BLTU,P,I,32'hfffffff0,32'd5), 1,1,0,0,0, 1,0,1,1, 0,P+4,1,1,0));
        tbl.push_back(vec("bge_eq", mk(1,1,0,BRU_BGE,P,I,32'h80000000,32'h80000000), 1,1,0,0,0, 1,0,1,1, 1,P+I,0,1,0));
        tbl.push_back(vec("bgeu_lo", mk(1,1,0,BRU_BGEU,P,I,32'd0,32'hffffffff), 1,1,0,0,0, 1,0,1,1, 0,P+4,1,1,0));
        tbl.push_back(vec("jalr", mk(1,1,0,BRU_JALR,P,32'h10,32'h1001,0), 1,1,0,0,0, 1,0,1,1, 1,32'h1010,0,1,P+4));
        tbl.push_back(vec("jal_wrap", mk(1,1,0,BRU_JAL,32'hfffffffc,32'd8,0,0), 1,1,0,0,0, 1,0,1,1, 1,32'd4,0,1,32'd0));
        tbl.push_back(vec("cm_noflush", mk(1,1,0,BRU_JAL,P,I,0,0), 1,1,1,0,0, 1,0,1,1, 1,P+I,0,1,P+4));
        tbl.push_back(vec("cm_flush", mk(1,1,0,BRU_JAL,P,I,0,0), 1,1,1,1,0, 0,1,0,0, 1,P+I,0,0,P+4));
        tbl.push_back(vec("in_reset", mk(1,1,0,BRU_JAL,P,I,0,0), 1,0,0,0,0, 0,1,0,0, 1,P+I,0,0,0));

        foreach (tbl[i]) begin
            v = tbl[i];
            apply(v.head, v.fv, v.r, v.cm, v.mepc);
            chk({v.name, ".we"}, 512'(we), 512'(v.we));
            chk({v.name, ".flush"}, 512'(flush), 512'(v.flush));
            chk({v.name, ".pop"}, 512'(pop), 512'(v.pop));
            chk({v.name, ".fb_en"}, 512'(fb.enable), 512'(v.fb_en));
            chk({v.name, ".fb_phy"}, 512'(fb.phy_id), 512'(v.fb_en ? 6'd10 : 6'd0));
            chk({v.name, ".fb_val"}, 512'(fb.value), 512'(v.fb_en ? v.rd_value : 32'd0));
            chk({v.name, ".jump"}, 512'(bp_jump), 512'(v.jump));
            chk({v.name, ".next"}, 512'(bp_next), 512'(v.next));
            chk({v.name, ".hit"}, 512'(bp_hit), 512'(v.hit));
            chk({v.name, ".bp_valid"}, 512'(bp_valid), 512'(v.bp_valid));
            chk({v.name, ".rd_value"}, 512'(wb.rd_value), 512'(v.rd_value));
            chk({v.name, ".cpbuf_id"}, 512'(cpbuf_id), 512'(6'd35));
            chk({v.name, ".bp_cp"}, 512'(bp_cp.local_history), 512'(32'h1574a2dc));
        end

        apply(mk(1,0,1,BRU_JAL,P,I,0,0), 1'b1, 1'b1, c0, 32'd0);
        chk("exc.wb_enable", 512'(wb.c.enable), 512'(1'b1));
        chk("exc.wb_valid", 512'(wb.c.valid), 512'(1'b0));
        chk("exc.wb_has_exc", 512'(wb.c.has_exception), 512'(1'b1));
        chk("exc.wb_exc_id", 512'(wb.c.exception_id), 512'(EXC_ILLEGAL_INSTRUCTION));

        apply(mk(1,1,0,BRU_JAL,P,I,0,0), 1'b1, 1'b1, c0, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_rst.we", 512'(we), 512'(1'b0));
        chk("async_rst.flush", 512'(flush), 512'(1'b1));
        chk("async_rst.wb", 512'(wb), 512'(0));
        chk("async_rst.bp_valid", 512'(bp_valid), 512'(1'b0));
        rst = 1'b1;
        #1;
        chk("async_rel.we", 512'(we), 512'(1'b1));
        chk("async_rel.wb_pc", 512'(wb.c.pc), 512'(P));

        cm.enable = 1'b1; cm.flush = 1'b1;
        apply(head, 1'b1, 1'b1, cm, 32'd0);
        chk("flush_cyc.pop", 512'(pop), 512'(1'b0));
        cm.flush = 1'b0;
        apply(head, 1'b1, 1'b1, cm, 32'd0);
        chk("after_flush.pop", 512'(pop), 512'(1'b1));
        chk("after_flush.fb_val", 512'(fb.value), 512'(P + 32'd4));

        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 10; k++) rb[k*32 +: 32] = $urandom();
            h = issue_execute_pack_t'(rb[$bits(issue_execute_pack_t)-1:0]);
            h.c.sub_op.bru_op = bru_op_t'($urandom_range(0, 8));
            h.c.enable = $urandom_range(0, 7) != 0;
            h.c.valid = $urandom_range(0, 7) != 0;
            h.c.has_exception = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 3) == 0) h.src2_value = h.src1_value;
            if ($urandom_range(0, 1) == 0) h.c.predicted_next_pc = h.c.pc + h.c.imm;
            c0.enable = $urandom_range(0, 1) == 1;
            c0.flush = $urandom_range(0, 3) == 0;
            cpd.global_history = $urandom();
            apply(h, $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, c0, $urandom());
            e = model(head, fv, rst, cm, mepc);
            chk("rnd.pop", 512'(pop), 512'(e.pop));
            chk("rnd.we", 512'(we), 512'(e.we));
            chk("rnd.flush", 512'(flush), 512'(e.flush));
            chk("rnd.wb", 512'(wb), 512'(e.wb));
            chk("rnd.fb", 512'(fb), 512'(e.fb));
            chk("rnd.jump", 512'(bp_jump), 512'(e.bp_jump));
            chk("rnd.next", 512'(bp_next), 512'(e.bp_next));
            chk("rnd.hit", 512'(bp_hit), 512'(e.bp_hit));
            chk("rnd.bp_valid", 512'(bp_valid), 512'(e.bp_valid));
            chk("rnd.bp_pc", 512'(bp_pc), 512'(h.c.pc));
            chk("rnd.bp_instr", 512'(bp_instr), 512'(h.value));
            chk("rnd.cpbuf_id", 512'(cpbuf_id), 512'(h.c.checkpoint_id));
            chk("rnd.bp_cp", 512'(bp_cp), 512'(cpd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
